// File: rtl/alu_result_writeback_if.sv
// Handshakes between the issue logic, the ALU writeback block and the register file:
// the op-tag issue channel and the buffered register-file write port.
interface alu_result_writeback_if #(
    parameter int ADDR_W = 4
);
    logic              issue_valid;
    logic              issue_ready;
    logic [4:0]        issue_opcode;
    logic [ADDR_W-1:0] issue_rd;
    logic              rf_we;
    logic              rf_ready;
    logic [ADDR_W-1:0] rf_waddr;
    logic [31:0]       rf_wdata;

    // Issue logic / register-file side
    modport master (
        output issue_valid, issue_opcode, issue_rd, rf_ready,
        input  issue_ready, rf_we, rf_waddr, rf_wdata
    );

    // Writeback block side
    modport slave (
        input  issue_valid, issue_opcode, issue_rd, rf_ready,
        output issue_ready, rf_we, rf_waddr, rf_wdata
    );
endinterface

// File: rtl/alu_result_writeback.sv
// Consumer end of the ALU pipeline: tracks issued op tags, samples c_reg when each result lands and
// routes it to a buffered register-file write port, the HI/LO pair, or the drop counter.
module alu_result_writeback #(
    parameter int LATENCY    = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 4
) (
    input  logic                  clk,
    input  logic                  clear,
    alu_result_writeback_if.slave wb,
    input  logic [63:0]           c_reg,
    output logic [31:0]           hi_q,
    output logic [31:0]           lo_q,
    output logic [7:0]            drop_count,
    output logic                  busy
);
    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FCNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int CRED_W  = $clog2(FIFO_DEPTH + LATENCY + 1);
    localparam int ENTRY_W = ADDR_W + 32;

    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
    localparam logic [FCNT_W-1:0] FCNT_ONE  = FCNT_W'(1);
    localparam logic [FCNT_W-1:0] FCNT_FULL = FCNT_W'(FIFO_DEPTH);
    localparam logic [CRED_W-1:0] CRED_MAX  = CRED_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {ROUTE_RF, ROUTE_HILO, ROUTE_DROP} route_t;

    logic [LATENCY-1:0] tag_valid;
    logic [4:0]         tag_opcode [LATENCY];
    logic [ADDR_W-1:0]  tag_rd     [LATENCY];

    logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [FCNT_W-1:0]  fifo_count_reg;
    logic [ENTRY_W-1:0] head_entry;

    logic [31:0] hi_reg;
    logic [31:0] lo_reg;
    logic [7:0]  drop_count_reg;

    logic              accept;
    logic              retire;
    logic              push;
    logic              pop;
    logic              fifo_nonempty;
    route_t            route;
    logic [CRED_W-1:0] tags_in_flight;
    logic [CRED_W-1:0] credits_used;

    assign accept = wb.issue_valid && wb.issue_ready;

    // One register stage per edge of ALU latency; the last stage lines up with c_reg.
    for (genvar gi = 0; gi < LATENCY; gi++) begin : g_tag_stage
        logic              valid_reg;
        logic [4:0]        opcode_reg;
        logic [ADDR_W-1:0] rd_reg;
        logic              valid_in;
        logic [4:0]        opcode_in;
        logic [ADDR_W-1:0] rd_in;

        if (gi == 0) begin : g_head
            assign valid_in  = accept;
            assign opcode_in = wb.issue_opcode;
            assign rd_in     = wb.issue_rd;
        end else begin : g_shift
            assign valid_in  = tag_valid[gi-1];
            assign opcode_in = tag_opcode[gi-1];
            assign rd_in     = tag_rd[gi-1];
        end

        always_ff @(posedge clk) begin
            if (clear) begin
                valid_reg <= 1'b0;
            end else begin
                valid_reg <= valid_in;
            end
            opcode_reg <= opcode_in;
            rd_reg     <= rd_in;
        end

        assign tag_valid[gi]  = valid_reg;
        assign tag_opcode[gi] = opcode_reg;
        assign tag_rd[gi]     = rd_reg;
    end

    assign retire = tag_valid[LATENCY-1];

    always_comb begin
        route = ROUTE_DROP;
        case (tag_opcode[LATENCY-1])
            5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000,
            5'b01001, 5'b01010, 5'b01011, 5'b10001, 5'b10010: route = ROUTE_RF;
            5'b10000, 5'b01111:                               route = ROUTE_HILO;
            default:                                          route = ROUTE_DROP;
        endcase
    end

    assign fifo_nonempty = (fifo_count_reg != '0);
    assign push          = retire && (route == ROUTE_RF);
    assign pop           = fifo_nonempty && wb.rf_ready;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_LAST) ? '0 : ptr + PTR_ONE;
    endfunction

    // Credits guarantee space for every push, so the write never checks for full.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= {tag_rd[LATENCY-1], c_reg[31:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            fifo_count_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= next_ptr(wr_ptr_reg);
            end
            if (pop) begin
                rd_ptr_reg <= next_ptr(rd_ptr_reg);
            end
            case ({push, pop})
                2'b10:   fifo_count_reg <= fifo_count_reg + FCNT_ONE;
                2'b01:   fifo_count_reg <= fifo_count_reg - FCNT_ONE;
                default: fifo_count_reg <= fifo_count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            hi_reg         <= '0;
            lo_reg         <= '0;
            drop_count_reg <= '0;
        end else if (retire) begin
            if (route == ROUTE_HILO) begin
                hi_reg <= c_reg[63:32];
                lo_reg <= c_reg[31:0];
            end
            if ((route == ROUTE_DROP) && (drop_count_reg != 8'hFF)) begin
                drop_count_reg <= drop_count_reg + 8'd1;
            end
        end
    end

    // Every in-flight tag holds a credit, whatever its eventual route.
    always_comb begin
        tags_in_flight = '0;
        for (int i = 0; i < LATENCY; i++) begin
            tags_in_flight = tags_in_flight + CRED_W'(tag_valid[i]);
        end
    end

    assign credits_used   = tags_in_flight + CRED_W'(fifo_count_reg);
    assign wb.issue_ready = (credits_used < CRED_MAX);

    assign head_entry  = fifo_mem[rd_ptr_reg];
    assign wb.rf_we    = fifo_nonempty;
    assign wb.rf_waddr = fifo_nonempty ? head_entry[ENTRY_W-1:32] : '0;
    assign wb.rf_wdata = fifo_nonempty ? head_entry[31:0] : '0;

    assign hi_q       = hi_reg;
    assign lo_q       = lo_reg;
    assign drop_count = drop_count_reg;
    assign busy       = (|tag_valid) || fifo_nonempty;

    a_fifo_bound: assert property (@(posedge clk) disable iff (clear) fifo_count_reg <= FCNT_FULL);
endmodule

// File: tb/tb_alu_result_writeback.sv
// Self-checking bench for alu_result_writeback: directed vector table, hand sequences for the
// multi-cycle corners, then randomized traffic against a queue-based reference model.
module tb_alu_result_writeback;
    localparam int ADDR_W = 4;
    localparam int LAT    = 2;
    localparam int DEPTH  = 4;

    localparam logic [4:0] OP_ADD = 5'b00011;
    localparam logic [4:0] OP_MUL = 5'b10000;
    localparam logic [4:0] OP_DIV = 5'b01111;
    localparam logic [4:0] OP_BAD = 5'b00000;

    logic        clk = 1'b0;
    logic        clear;
    logic [63:0] c_reg;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [7:0]  drop_count;
    logic        busy;

    alu_result_writeback_if #(.ADDR_W(ADDR_W)) bus ();

    alu_result_writeback #(.LATENCY(LAT), .FIFO_DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk),
        .clear(clear),
        .wb(bus),
        .c_reg(c_reg),
        .hi_q(hi_q),
        .lo_q(lo_q),
        .drop_count(drop_count),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model: ops waiting for their result, and register writes waiting for the RF.
    typedef struct {
        logic [4:0]        op;
        logic [ADDR_W-1:0] rd;
        int                due;
    } pend_t;

    typedef struct {
        logic [ADDR_W-1:0] rd;
        logic [31:0]       data;
    } wr_t;

    typedef struct {
        logic              v;
        logic [4:0]        op;
        logic [ADDR_W-1:0] rd;
        logic              rdy;
        logic [63:0]       c;
        logic              e_we;
        logic [ADDR_W-1:0] e_waddr;
        logic [31:0]       e_wdata;
        logic [31:0]       e_hi;
        logic [31:0]       e_lo;
        logic              e_ready;
        logic              e_busy;
    } vec_t;

    pend_t       pend_q[$];
    wr_t         fifo_q[$];
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    int          m_drop;
    int          cyc;
    int          n_checks;
    int          n_errors;
    vec_t        vecs [12];
    logic [4:0]  rf_ops [11] = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000,
                                 5'b01001, 5'b01010, 5'b01011, 5'b10001, 5'b10010};

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_step(input logic clr, input logic v, input logic [4:0] op,
                              input logic [ADDR_W-1:0] rd, input logic rdy, input logic [63:0] c);
        bit    acc;
        bit    do_pop;
        pend_t t;
        wr_t   w;
        if (clr) begin
            pend_q.delete();
            fifo_q.delete();
            m_hi   = '0;
            m_lo   = '0;
            m_drop = 0;
        end else begin
            acc    = v && ((fifo_q.size() + pend_q.size()) < DEPTH);
            do_pop = (fifo_q.size() != 0) && rdy;
            if (do_pop) begin
                w = fifo_q.pop_front();
                $display("rf write: cycle=%0d addr=%0d data=%08h", cyc, w.rd, w.data);
            end
            if ((pend_q.size() != 0) && (pend_q[0].due == cyc)) begin
                t = pend_q.pop_front();
                if (t.op inside {5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000,
                                 5'b01001, 5'b01010, 5'b01011, 5'b10001, 5'b10010}) begin
                    fifo_q.push_back('{t.rd, c[31:0]});
                end else if (t.op inside {OP_MUL, OP_DIV}) begin
                    m_hi = c[63:32];
                    m_lo = c[31:0];
                end else if (m_drop < 255) begin
                    m_drop++;
                end
            end
            if (acc) begin
                pend_q.push_back('{op, rd, cyc + LAT});
            end
        end
        cyc++;
    endtask

    task automatic check_model();
        bit          we;
        logic [63:0] e_addr;
        logic [63:0] e_data;
        we     = (fifo_q.size() != 0);
        e_addr = 64'd0;
        e_data = 64'd0;
        if (we) begin
            e_addr = 64'(fifo_q[0].rd);
            e_data = 64'(fifo_q[0].data);
        end
        chk("rf_we", 64'(bus.rf_we), 64'(we));
        chk("rf_waddr", 64'(bus.rf_waddr), e_addr);
        chk("rf_wdata", 64'(bus.rf_wdata), e_data);
        chk("hi_q", 64'(hi_q), 64'(m_hi));
        chk("lo_q", 64'(lo_q), 64'(m_lo));
        chk("drop_count", 64'(drop_count), 64'(m_drop));
        chk("issue_ready", 64'(bus.issue_ready), 64'((fifo_q.size() + pend_q.size()) < DEPTH));
        chk("busy", 64'(busy), 64'((fifo_q.size() != 0) || (pend_q.size() != 0)));
    endtask

    task automatic cycle(input logic clr, input logic v, input logic [4:0] op,
                         input logic [ADDR_W-1:0] rd, input logic rdy, input logic [63:0] c);
        clear            = clr;
        bus.issue_valid  = v;
        bus.issue_opcode = op;
        bus.issue_rd     = rd;
        bus.rf_ready     = rdy;
        c_reg            = c;
        @(posedge clk);
        model_step(clr, v, op, rd, rdy, c);
        #1;
        check_model();
    endtask

    initial begin
        logic [63:0] x1;
        logic [63:0] x2;
        logic [4:0]  op;
        int          sel;

        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        m_hi     = '0;
        m_lo     = '0;
        m_drop   = 0;
        x1       = 64'h1234_5678_9abc_def0;
        x2       = 64'hcafe_f00d_dead_beef;

        // Reset
        cycle(1'b1, 1'b0, OP_BAD, '0, 1'b0, 64'd0);
        cycle(1'b1, 1'b0, OP_BAD, '0, 1'b0, 64'd0);
        chk("reset_rf_we", 64'(bus.rf_we), 64'd0);
        chk("reset_rf_waddr", 64'(bus.rf_waddr), 64'd0);
        chk("reset_rf_wdata", 64'(bus.rf_wdata), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_issue_ready", 64'(bus.issue_ready), 64'd1);
        chk("reset_drop", 64'(drop_count), 64'd0);

        // ADD -> RF write; MUL -> HI/LO; push and pop on the same edge with one entry
        vecs[0]  = '{1'b1, OP_ADD, 4'd5, 1'b1, 64'd0,  1'b0, 4'd0, 32'd0,    32'd0, 32'd0,          1'b1, 1'b1};
        vecs[1]  = '{1'b0, OP_BAD, 4'd0, 1'b1, 64'd0,  1'b0, 4'd0, 32'd0,    32'd0, 32'd0,          1'b1, 1'b1};
        vecs[2]  = '{1'b0, OP_BAD, 4'd0, 1'b1, 64'd7,  1'b1, 4'd5, 32'd7,    32'd0, 32'd0,          1'b1, 1'b1};
        vecs[3]  = '{1'b0, OP_BAD, 4'd0, 1'b1, 64'd0,  1'b0, 4'd0, 32'd0,    32'd0, 32'd0,          1'b1, 1'b0};
        vecs[4]  = '{1'b1, OP_MUL, 4'd3, 1'b1, 64'd0,  1'b0, 4'd0, 32'd0,    32'd0, 32'd0,          1'b1, 1'b1};
        vecs[5]  = '{1'b0, OP_BAD, 4'd0, 1'b1, 64'd0,  1'b0, 4'd0, 32'd0,    32'd0, 32'd0,          1'b1, 1'b1};
        vecs[6]  = '{1'b0, OP_BAD, 4'd0, 1'b1, 64'h0000_0001_8000_0000,
                                                       1'b0, 4'd0, 32'd0,    32'd1, 32'h8000_0000,  1'b1, 1'b0};
        vecs[7]  = '{1'b1, OP_ADD, 4'd1, 1'b0, 64'd0,  1'b0, 4'd0, 32'd0,    32'd1, 32'h8000_0000,  1'b1, 1'b1};
        vecs[8]  = '{1'b1, OP_ADD, 4'd2, 1'b0, 64'd0,  1'b0, 4'd0, 32'd0,    32'd1, 32'h8000_0000,  1'b1, 1'b1};
        vecs[9]  = '{1'b0, OP_BAD, 4'd0, 1'b0, 64'h11, 1'b1, 4'd1, 32'h11,   32'd1, 32'h8000_0000,  1'b1, 1'b1};
        vecs[10] = '{1'b0, OP_BAD, 4'd0, 1'b1, 64'h22, 1'b1, 4'd2, 32'h22,   32'd1, 32'h8000_0000,  1'b1, 1'b1};
        vecs[11] = '{1'b0, OP_BAD, 4'd0, 1'b1, 64'd0,  1'b0, 4'd0, 32'd0,    32'd1, 32'h8000_0000,  1'b1, 1'b0};

        for (int i = 0; i < 12; i++) begin
            cycle(1'b0, vecs[i].v, vecs[i].op, vecs[i].rd, vecs[i].rdy, vecs[i].c);
            chk($sformatf("vec%0d_rf_we", i), 64'(bus.rf_we), 64'(vecs[i].e_we));
            chk($sformatf("vec%0d_rf_waddr", i), 64'(bus.rf_waddr), 64'(vecs[i].e_waddr));
            chk($sformatf("vec%0d_rf_wdata", i), 64'(bus.rf_wdata), 64'(vecs[i].e_wdata));
            chk($sformatf("vec%0d_hi_q", i), 64'(hi_q), 64'(vecs[i].e_hi));
            chk($sformatf("vec%0d_lo_q", i), 64'(lo_q), 64'(vecs[i].e_lo));
            chk($sformatf("vec%0d_issue_ready", i), 64'(bus.issue_ready), 64'(vecs[i].e_ready));
            chk($sformatf("vec%0d_busy", i), 64'(busy), 64'(vecs[i].e_busy));
            chk($sformatf("vec%0d_drop", i), 64'(drop_count), 64'd0);
        end

        // Credits run out with the RF stalled, then drain in issue order
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b1, OP_ADD, ADDR_W'(8 + i), 1'b0, rnd64());
        end
        chk("credits_exhausted", 64'(bus.issue_ready), 64'd0);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b0, OP_BAD, '0, 1'b0, rnd64());
            chk("credits_held", 64'(bus.issue_ready), 64'd0);
            chk("stall_head_addr", 64'(bus.rf_waddr), 64'd8);
        end
        for (int i = 0; i < 4; i++) begin
            chk("drain_order", 64'(bus.rf_waddr), 64'(8 + i));
            cycle(1'b0, 1'b0, OP_BAD, '0, 1'b1, rnd64());
            if (i == 0) begin
                chk("credit_returned", 64'(bus.issue_ready), 64'd1);
            end
        end
        chk("drained_rf_we", 64'(bus.rf_we), 64'd0);

        // MUL then DIV back to back: DIV result wins one edge later
        cycle(1'b0, 1'b1, OP_MUL, 4'd0, 1'b1, rnd64());
        cycle(1'b0, 1'b1, OP_DIV, 4'd0, 1'b1, rnd64());
        cycle(1'b0, 1'b0, OP_BAD, 4'd0, 1'b1, x1);
        chk("mul_hi", 64'(hi_q), 64'(x1[63:32]));
        chk("mul_lo", 64'(lo_q), 64'(x1[31:0]));
        cycle(1'b0, 1'b0, OP_BAD, 4'd0, 1'b1, x2);
        chk("div_hi", 64'(hi_q), 64'(x2[63:32]));
        chk("div_lo", 64'(lo_q), 64'(x2[31:0]));

        // Unsupported opcode issued 300 times: drop counter saturates, HI/LO untouched
        for (int i = 0; i < 300; i++) begin
            cycle(1'b0, 1'b1, OP_BAD, ADDR_W'($urandom_range(0, 15)), 1'b1, rnd64());
        end
        cycle(1'b0, 1'b0, OP_BAD, '0, 1'b1, rnd64());
        cycle(1'b0, 1'b0, OP_BAD, '0, 1'b1, rnd64());
        chk("drop_saturated", 64'(drop_count), 64'd255);
        chk("drop_hi_kept", 64'(hi_q), 64'(x2[63:32]));
        chk("drop_no_write", 64'(bus.rf_we), 64'd0);

        // Clear with two ADDs in flight and one FIFO entry
        cycle(1'b0, 1'b1, OP_ADD, 4'd6, 1'b0, rnd64());
        cycle(1'b0, 1'b0, OP_BAD, 4'd0, 1'b0, rnd64());
        cycle(1'b0, 1'b1, OP_ADD, 4'd7, 1'b0, rnd64());
        cycle(1'b0, 1'b1, OP_ADD, 4'd8, 1'b0, rnd64());
        chk("pre_clear_busy", 64'(busy), 64'd1);
        chk("pre_clear_head", 64'(bus.rf_waddr), 64'd6);
        cycle(1'b1, 1'b1, OP_ADD, 4'd9, 1'b0, rnd64());
        chk("clear_busy", 64'(busy), 64'd0);
        chk("clear_rf_we", 64'(bus.rf_we), 64'd0);
        chk("clear_issue_ready", 64'(bus.issue_ready), 64'd1);
        chk("clear_hi", 64'(hi_q), 64'd0);
        chk("clear_lo", 64'(lo_q), 64'd0);
        chk("clear_drop", 64'(drop_count), 64'd0);
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 1'b0, OP_BAD, '0, 1'b1, rnd64());
            chk("post_clear_no_write", 64'(bus.rf_we), 64'd0);
        end

        // Randomized traffic against the reference model
        for (int i = 0; i < 1500; i++) begin
            sel = $urandom_range(0, 3);
            if (sel < 2) begin
                op = rf_ops[$urandom_range(0, 10)];
            end else if (sel == 2) begin
                op = ($urandom_range(0, 1) != 0) ? OP_MUL : OP_DIV;
            end else begin
                op = 5'($urandom_range(0, 31));
            end
            cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 7), op,
                  ADDR_W'($urandom_range(0, 15)), ($urandom_range(0, 9) < 7), rnd64());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
